// File: rtl/wb_pkg.sv
// Shared widths and the load-queue entry layout for the write-back commit unit.
package wb_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic            data_ok;
        logic [XLEN-1:0] data;
    } lq_entry_t;
endpackage

// File: rtl/wb_load_queue.sv
// In-order queue of outstanding loads: allocation at the tail, fill of the oldest
// entry still waiting for data, retire from the head, and an rd-match CAM for hazards.
module wb_load_queue
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_i,
    input  logic [AW-1:0]   issue_rd_i,
    input  logic            resp_valid_i,
    input  logic [XLEN-1:0] resp_data_i,
    input  logic            retire_i,
    input  logic [AW-1:0]   chk_a_i,
    input  logic [AW-1:0]   chk_b_i,
    input  logic [AW-1:0]   chk_c_i,
    output logic            ready_o,
    output logic            head_ready_o,
    output logic [AW-1:0]   head_rd_o,
    output logic [XLEN-1:0] head_data_o,
    output logic            resp_err_o,
    output logic            match_a_o,
    output logic            match_b_o,
    output logic            match_c_o
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;

    lq_entry_t     ent_q [LQ_DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic          alloc;
    logic          deq;
    logic          fill_found;
    logic [PW-1:0] fill_idx;
    logic [PW-1:0] idx;

    assign ready_o      = (count_q != CW'(LQ_DEPTH));
    assign alloc        = issue_i && ready_o;
    assign head_ready_o = ent_q[head_q].valid && ent_q[head_q].data_ok;
    assign head_rd_o    = ent_q[head_q].rd;
    assign head_data_o  = ent_q[head_q].data;
    assign deq          = retire_i && head_ready_o;
    assign resp_err_o   = resp_valid_i && !fill_found;

    // Valid entries are contiguous from the head, so the first hit walking
    // forward from the head is the oldest entry still awaiting its data.
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = head_q;
        idx        = head_q;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (!fill_found && ent_q[idx].valid && !ent_q[idx].data_ok) begin
                fill_found = 1'b1;
                fill_idx   = idx;
            end
        end
    end

    always_comb begin
        match_a_o = 1'b0;
        match_b_o = 1'b0;
        match_c_o = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            match_a_o = match_a_o | (ent_q[i].valid && ent_q[i].rd == chk_a_i);
            match_b_o = match_b_o | (ent_q[i].valid && ent_q[i].rd == chk_b_i);
            match_c_o = match_c_o | (ent_q[i].valid && ent_q[i].rd == chk_c_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                ent_q[i].valid   <= 1'b0;
                ent_q[i].data_ok <= 1'b0;
            end
        end else begin
            if (alloc) begin
                ent_q[tail_q].valid   <= 1'b1;
                ent_q[tail_q].rd      <= issue_rd_i;
                ent_q[tail_q].data_ok <= 1'b0;
                tail_q                <= tail_q + 1'b1;
            end
            if (resp_valid_i && fill_found) begin
                ent_q[fill_idx].data_ok <= 1'b1;
                ent_q[fill_idx].data    <= resp_data_i;
            end
            if (deq) begin
                ent_q[head_q].valid <= 1'b0;
                head_q              <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(alloc) - CW'(deq);
        end
    end
endmodule

// File: rtl/wb_commit_unit.sv
// Register-file write-port owner: arbitrates ALU results against in-order load
// returns, and raises a decode stall for registers whose values are still in flight.
module wb_commit_unit
    import wb_pkg::*;
#(
    parameter int XLEN     = wb_pkg::XLEN,
    parameter int AW       = wb_pkg::AW,
    parameter int LQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_rd,
    output logic            ld_issue_ready,
    input  logic            ld_resp_valid,
    input  logic [XLEN-1:0] ld_resp_data,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    input  logic [AW-1:0]   chk_rd,
    output logic            stall,
    output logic            ld_resp_err,
    output logic            regWr,
    output logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd_data
);
    logic            alu_win;
    logic            head_ready;
    logic [AW-1:0]   head_rd;
    logic [XLEN-1:0] head_data;
    logic            resp_err;
    logic            m_rs1, m_rs2, m_rd;

    logic            wr_en_d, wr_en_q;
    logic [AW-1:0]   wr_addr_d, wr_addr_q;
    logic [XLEN-1:0] wr_data_d, wr_data_q;
    logic            err_q;

    // An ALU write to x0 is dropped anyway, so it does not take the port from the head.
    assign alu_win = alu_valid && (alu_rd != '0);

    wb_load_queue #(.LQ_DEPTH(LQ_DEPTH)) u_lq (
        .clk          (clk),
        .reset        (reset),
        .issue_i      (ld_issue),
        .issue_rd_i   (ld_rd),
        .resp_valid_i (ld_resp_valid),
        .resp_data_i  (ld_resp_data),
        .retire_i     (!alu_win),
        .chk_a_i      (chk_rs1),
        .chk_b_i      (chk_rs2),
        .chk_c_i      (chk_rd),
        .ready_o      (ld_issue_ready),
        .head_ready_o (head_ready),
        .head_rd_o    (head_rd),
        .head_data_o  (head_data),
        .resp_err_o   (resp_err),
        .match_a_o    (m_rs1),
        .match_b_o    (m_rs2),
        .match_c_o    (m_rd)
    );

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (alu_win) begin
            wr_en_d   = 1'b1;
            wr_addr_d = alu_rd;
            wr_data_d = alu_data;
        end else if (head_ready && head_rd != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = head_rd;
            wr_data_d = head_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_q | resp_err;
        end
    end

    function automatic logic hazard(input logic [AW-1:0] x, input logic in_queue);
        return (x != '0) && (in_queue || (wr_en_q && wr_addr_q == x));
    endfunction

    assign stall       = hazard(chk_rs1, m_rs1) || hazard(chk_rs2, m_rs2) || hazard(chk_rd, m_rd);
    assign ld_resp_err = err_q;
    assign regWr       = wr_en_q;
    assign rd_addr     = wr_addr_q;
    assign rd_data     = wr_data_q;
endmodule
